// File: rtl/special_alu_sched.sv
// special_alu_sched: round-robin scheduler sharing one special_alu
// between NREQ requesters (load, execute, drain, respond).
module special_alu_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_op,
  input  logic [3*NREQ-1:0]   req_len,
  input  logic [NREQ-1:0]     opd_valid,
  input  logic [8*NREQ-1:0]   opd_data,
  output logic [NREQ-1:0]     opd_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [10:0]         rsp_result,
  output logic                rsp_err,
  output logic                alu_a_valid,
  output logic [7:0]          alu_a_operand,
  input  logic                alu_a_ready,
  input  logic                alu_b_valid,
  input  logic [10:0]         alu_b_result,
  output logic                alu_b_ready,
  output logic [2:0]          alu_b_operation
);

  typedef enum logic [2:0] {
    IDLE, LOAD, EXEC, DRAIN, RESP
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0] g, last, pick, cand;
  logic           found;
  logic [2:0]     op, len;
  logic [3:0]     occ;
  logic           a_hs, err_job;

  logic [7:0] data_a [NREQ];
  logic [2:0] op_a   [NREQ];
  logic [2:0] len_a  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_a[i] = opd_data[8*i +: 8];
    assign op_a[i]   = req_op[3*i +: 3];
    assign len_a[i]  = req_len[3*i +: 3];
  end

  // Search starts one past the last winner and wraps at NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == IDW'(NREQ - 1)) cand = '0;
      else cand = cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign a_hs    = (state == LOAD) && opd_valid[g] && alu_a_ready;
  assign err_job = !op[2] && (len == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = LOAD;
      LOAD:  if (a_hs && occ == {1'b0, len}) state_nx = EXEC;
      EXEC: begin
        if (err_job) state_nx = DRAIN;
        else if (alu_b_valid)
          state_nx = (occ == 4'd1) ? RESP : DRAIN;
      end
      DRAIN: if (alu_b_valid && occ == 4'd1) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // b_ready stays low in LOAD: the ALU folds it into a_ready.
  always_comb begin
    alu_a_valid     = 1'b0;
    alu_a_operand   = '0;
    alu_b_ready     = 1'b0;
    alu_b_operation = '0;
    opd_ready       = '0;
    unique case (state)
      LOAD: begin
        alu_a_valid   = opd_valid[g];
        alu_a_operand = data_a[g];
        opd_ready[g]  = alu_a_ready;
      end
      EXEC: begin
        alu_b_ready     = 1'b1;
        alu_b_operation = op;
      end
      DRAIN: begin
        alu_b_ready     = 1'b1;
        alu_b_operation = 3'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g          <= '0;
      last       <= IDW'(NREQ - 1);
      op         <= '0;
      len        <= '0;
      occ        <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= (state_nx == RESP);
      if (state_nx == RESP) rsp_id <= g;
      unique case (state)
        IDLE: if (found) begin
          g               <= pick;
          last            <= pick;
          op              <= op_a[pick];
          len             <= len_a[pick];
          occ             <= '0;
          rsp_err         <= 1'b0;
          req_ready[pick] <= 1'b1;
        end
        LOAD: if (a_hs) occ <= occ + 4'd1;
        EXEC: begin
          if (err_job) begin
            rsp_err    <= 1'b1;
            rsp_result <= '0;
          end else if (alu_b_valid) begin
            rsp_result <= alu_b_result;
            rsp_err    <= 1'b0;
            occ        <= occ - 4'd1;
          end
        end
        DRAIN: if (alu_b_valid) occ <= occ - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/special_alu_sched.md
# special_alu_sched

Round-robin job scheduler that shares one `special_alu` instance between `NREQ` requesters. Each requester submits a job: an operation, an operand count, and a stream of 8-bit operands. The scheduler grants one job at a time and streams its operands into the ALU's a-channel. It then executes the operation on the b-channel, drains leftover ALU FIFO entries, and returns the 11-bit result on a shared response port tagged with the requester index.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester index width, `$clog2(NREQ)`

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  job command valid, one bit per requester
- `req_ready`  out  NREQ  one-cycle accept pulse for the granted command
- `req_op`  in  3*NREQ  per-requester ALU op code; slice i = [3i+2:3i]
- `req_len`  in  3*NREQ  per-requester operand count minus 1 (0 means 1 operand, 7 means 8)
- `opd_valid`  in  NREQ  operand valid
- `opd_data`  in  8*NREQ  operand data; slice i = [8i+7:8i]
- `opd_ready`  out  NREQ  operand accept
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  IDW  index of the requester that owns the response
- `rsp_result`  out  11  ALU result
- `rsp_err`  out  1  job rejected
- `alu_a_valid`  out  1  connects to ALU `a_valid`
- `alu_a_operand`  out  8  connects to ALU `a_operand`
- `alu_a_ready`  in  1  connects to ALU `a_ready`
- `alu_b_valid`  in  1  connects to ALU `b_valid`
- `alu_b_result`  in  11  connects to ALU `b_result`
- `alu_b_ready`  out  1  connects to ALU `b_ready`
- `alu_b_operation`  out  3  connects to ALU `b_operation`
- The ALU's reset is driven as `rstn = ~rst` at the integration level, so the ALU and the scheduler reset together.

## Operation
- **Op codes** are the ALU's: 0 ADD2, 1 SUB2, 2 OR2, 3 AND2, 4 OR, 5 AND, 6 SUM, 7 AVG.
- **State machine** states are IDLE, LOAD, EXEC, DRAIN, RESP. Each job latches `g`, `op` and `len` at grant.
- **IDLE:** round-robin arbitration over `req_valid`.
  - Search starts at `last+1` (mod `NREQ`).
  - Drive `req_ready[g]=1` for one cycle and latch `g`, `op`, `len`.
  - Set `last<=g`, `occ<=0`, then go to LOAD.
- **LOAD:** `alu_a_valid=opd_valid[g]`, `alu_a_operand=opd_data[g]`, `opd_ready[g]=alu_a_ready`.
  - `alu_b_ready=0` throughout LOAD, because the ALU ORs `b_ready` into `a_ready`.
  - Each a-handshake increments `occ`.
  - After `len+1` handshakes, go to EXEC.
  - `opd_ready` of every non-granted requester is 0.
- **EXEC:** `alu_b_operation=op`, `alu_b_ready=1`.
  - On `alu_b_valid`, capture `alu_b_result` into `rsp_result` and decrement `occ`.
  - If `occ` becomes 0, go to RESP; otherwise go to DRAIN.
- **Error path:** a pair op (op<4) with `len==0` is an error job.
  - Its single operand is still loaded.
  - EXEC does not wait for `alu_b_valid`. It sets `rsp_err=1` and `rsp_result=0`, then goes to DRAIN with `occ=1`.
- **DRAIN:** `alu_b_operation=4` (OR, valid whenever ALU cnt>0), `alu_b_ready=1`.
  - Each b-handshake decrements `occ`.
  - Go to RESP when `occ` reaches 0.
  - On exit the ALU FIFO is empty.
- **RESP:** `rsp_valid=1` with `rsp_id=g`.
  - On `rsp_ready`, go to IDLE.
  - `rsp_*` hold stable while `rsp_valid & !rsp_ready`.
- **Counter width:** `occ` is 4 bits, range 0..8. The ALU never exceeds 8 entries, so `a_ready` is never dropped by the ALU.
- **Non-granted requesters** see `req_ready=0` and `opd_ready=0`. Their requests wait and are never lost.

## Timing
- **Reset values:**
  - `req_ready`, `opd_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`: 0.
  - `alu_a_valid`, `alu_b_ready`, `alu_b_operation`: 0.
  - State is IDLE.
  - `last=NREQ-1`, so requester 0 wins the first arbitration.
- **Reset mid-job:** the job is abandoned with no response. The ALU is reset by the same event.
- **Minimum latency** from `req_valid` to `rsp_valid`, with no stalls: 1 (IDLE) + (len+1) (LOAD) + 1 (EXEC) + len (DRAIN) cycles. `rsp_valid` asserts on the following cycle.
- **Grant timing:** only one job is in flight. The next grant happens at the earliest in the cycle after the RESP handshake.
- **Outputs:** the `alu_*` outputs are combinational from state and the granted index. `req_ready`, `rsp_*` and state are registered.
- **Operand stalls:** `opd_valid[g]` may drop at any point in LOAD. The scheduler waits indefinitely without a timeout.
- **Simultaneous requests:** when all `req_valid` bits are held high, grants rotate 0,1,...,NREQ-1,0.

## Test plan
- **SUM:** req0, op 6, len 2, operands 10,20,30 -> `rsp_result=60`, `rsp_id=0`, `rsp_err=0`. RESP is reached 6 cycles after the grant cycle.
- **SUB2:** req1, op 1, len 1, operands 5,7 -> `rsp_result=11'h7FE`. Then SUM of a single operand 9 -> 9, which proves the ALU was drained.
- **AVG:** op 7, len 7, eight operands of 255 -> `rsp_result=255`. `occ` reaches 8 and `alu_a_ready` stays 1 throughout.
- **Contention:** req0..req3 held valid, each job ADD2 of 1,2 -> four responses, `rsp_id` sequence 0,1,2,3, all `rsp_result=3`.
- **Error job and stalls:** op 3 with len 0 and operand 0xAA -> `rsp_err=1`, `rsp_result=0`, next job correct.
  - `opd_valid` gaps of 3 cycles in LOAD, and `rsp_ready` held low 5 cycles with `rsp_*` held stable -> same results.
- **Reset mid-LOAD:** `rst` after 2 of 4 operands -> all outputs at reset values and no response. A subsequent OR of 0x0F,0xF0 -> 0xFF.
